// File: rtl/my_arith_pkg.sv
// Shared arithmetic definitions for the sequential multiplier slice.
//   WORD_W      - datapath width
//   mul_state_t - multiplier controller states
//   step_t      - shift-and-add step counter
package my_arith_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

    typedef logic [3:0] step_t;

endpackage

// File: rtl/my_add16.sv
// 16-bit wrap-around adder; the only arithmetic resource of the multiplier.
//   a, b - addends
//   sum  - (a + b) mod 2^16, carry discarded
module my_add16
    import my_arith_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/my_mul16_seq.sv
// Sequential shift-and-add multiplier, one add/shift step per clock.
//   clk, rst_n           - clock, asynchronous active-low reset
//   flush                - synchronous abort back to IDLE
//   in_valid/in_ready, a, b        - operand handshake (accept only in IDLE)
//   out_valid/out_ready, product   - result handshake, product = (a*b) mod 2^16
//   busy                 - controller not in IDLE
module my_mul16_seq
    import my_arith_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] product,
    output logic              busy
);

    mul_state_t        state_q;
    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] mcand_q;
    logic [WORD_W-1:0] mplier_q;
    step_t             step_q;
    logic [WORD_W-1:0] product_q;

    logic [WORD_W-1:0] add_sum;
    logic [WORD_W-1:0] acc_d;
    logic [WORD_W-1:0] mplier_d;
    logic              run_exit;

    my_add16 u_add (
        .a   (acc_q),
        .b   (mcand_q),
        .sum (add_sum)
    );

    always_comb begin
        acc_d    = mplier_q[0] ? add_sum : acc_q;
        mplier_d = mplier_q >> 1;
        run_exit = (step_q == step_t'(15)) || (EARLY_EXIT && (mplier_d == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            step_q    <= '0;
            product_q <= '0;
        end else if (flush) begin
            state_q   <= IDLE;
            product_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q    <= '0;
                        mcand_q  <= a;
                        mplier_q <= b;
                        step_q   <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_d;
                    if (run_exit) begin
                        // Counter holds on exit so it never wraps past 15.
                        product_q <= acc_d;
                        state_q   <= DONE;
                    end else begin
                        step_q <= step_q + step_t'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;

endmodule

// File: tb/tb_my_mul16_seq.sv
// Directed bench: runs the same operands through an EARLY_EXIT=0 and an EARLY_EXIT=1 instance
// and checks latency, product, back-pressure, flush and asynchronous reset.
module tb_my_mul16_seq;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_ready;

    logic        in_ready0, out_valid0, busy0;
    logic        in_ready1, out_valid1, busy1;
    logic [15:0] product0, product1;

    int n_checks;
    int n_fail;

    my_mul16_seq #(.EARLY_EXIT(1'b0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .a         (a),
        .b         (b),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .product   (product0),
        .busy      (busy0)
    );

    my_mul16_seq #(.EARLY_EXIT(1'b1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .a         (a),
        .b         (b),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .product   (product1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present operands for exactly one accept edge (both instances are in IDLE).
    task automatic accept(input logic [15:0] va, input logic [15:0] vb);
        @(negedge clk);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Operation with hand-computed product and EARLY_EXIT=1 step count n1.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] exp_prod, input int n1, input int hold);
        int lat0;
        int lat1;
        logic [15:0] p0;
        lat0 = 0;
        lat1 = 0;
        out_ready = 1'b0;
        accept(va, vb);
        // Bounded wait; a missing out_valid leaves the latency at 0 and fails below.
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid0 && lat0 == 0) lat0 = c;
            if (out_valid1 && lat1 == 0) lat1 = c;
        end
        check_eq({tag, " lat0"}, lat0, 16);
        check_eq({tag, " lat1"}, lat1, n1);
        check_eq({tag, " prod0"}, product0, exp_prod);
        check_eq({tag, " prod1"}, product1, exp_prod);
        if (hold > 0) begin
            p0 = product0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_eq({tag, " hold"}, {out_valid0, out_valid1, in_ready0, in_ready1,
                                          (product0 == p0)}, 5'b11001);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, " release"}, {in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1},
                 6'b110000);
    endtask

    initial begin
        int seen;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        #22;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset ctl", {in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1},
                 6'b110000);
        check_eq("reset prod", {product0, product1}, 32'h0);

        run_op("3x5", 16'd3, 16'd5, 16'h000F, 3, 0);
        run_op("m1xm1", 16'hFFFF, 16'hFFFF, 16'h0001, 16, 0);
        run_op("7x1", 16'd7, 16'd1, 16'h0007, 1, 0);
        run_op("bzero", 16'h1234, 16'h0000, 16'h0000, 1, 0);
        run_op("bpress", 16'h0102, 16'h0030, 16'h3060, 6, 10);

        // Flush during step 6 of a long operation.
        accept(16'h00FF, 16'h0101);
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush idle", {busy0, busy1, in_ready0, in_ready1}, 4'b0011);
        check_eq("flush prod", {product0, product1}, 32'h0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid0 || out_valid1) seen++;
        end
        check_eq("flush no ov", seen, 0);

        // Flush beats accept on the same edge.
        @(negedge clk);
        a        = 16'd9;
        b        = 16'd9;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check_eq("flush vs acc", {busy0, busy1}, 2'b00);

        run_op("2x3", 16'd2, 16'd3, 16'h0006, 2, 0);

        // Asynchronous reset between edges mid-RUN.
        accept(16'h00FF, 16'h0101);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst ctl", {busy0, busy1, out_valid0, out_valid1}, 4'b0000);
        check_eq("rst prod", {product0, product1}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("8000x2", 16'h8000, 16'h0002, 16'h0000, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
